alu_operand_stage: RTL

- Pipeline stage directly upstream of the 16-bit clocked ALU.
- Registers decoded operands and the opcode, and selects immediate vs register data for the second operand.
- Forwards the ALU's registered result to dependent instructions.
- Inserts a one-cycle bubble when an instruction depends on the result still being computed. Also supports flush on redirect.

---
 rtl/alu_operand_stage_pkg.sv | 27 ++
 rtl/alu_operand_stage_if.sv | 42 ++++
 rtl/alu_operand_stage_fwd_select.sv | 20 ++
 rtl/alu_operand_stage.sv | 84 ++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared widths, ALU opcodes and pipeline tag type for the operand stage
// Contents: DATA_WIDTH/REG_ADDR_W/IMM_WIDTH, alu_op_e, tag_t {valid, writes, dest},
// tag_hit (source-vs-tag dependency test), sext_imm (immediate sign extension).
package alu_operand_stage_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int REG_ADDR_W = 3;
    localparam int IMM_WIDTH  = 8;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_SHL, ALU_SHR, ALU_XOR
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic                  writes;
        logic [REG_ADDR_W-1:0] dest;
    } tag_t;

    // r0 is hard-wired zero, so a tag targeting it never produces a dependency
    function automatic logic tag_hit(tag_t t, logic [REG_ADDR_W-1:0] idx);
        return t.valid && t.writes && (t.dest != '0) && (t.dest == idx);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sext_imm(logic [IMM_WIDTH-1:0] imm);
        return {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endfunction
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode/ALU/writeback bundle around the operand stage
// master: decode + register file + ALU side (drives instruction, read data, AluResult)
// slave:  the operand stage (drives InReady, issued operands/opcode and result tags)
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;
    logic                  InValid;
    logic                  InReady;
    logic [2:0]            ALUOpIn;
    logic [REG_ADDR_W-1:0] SrcRegA;
    logic [REG_ADDR_W-1:0] SrcRegB;
    logic [REG_ADDR_W-1:0] DestRegIn;
    logic                  WritesReg;
    logic [DATA_WIDTH-1:0] RegDataA;
    logic [DATA_WIDTH-1:0] RegDataB;
    logic [IMM_WIDTH-1:0]  Immediate;
    logic                  UseImm;
    logic                  Flush;
    logic [DATA_WIDTH-1:0] AluResult;
    logic [DATA_WIDTH-1:0] FirstInput;
    logic [DATA_WIDTH-1:0] SecondInput;
    logic [2:0]            ALUOp;
    logic                  OutValid;
    logic [REG_ADDR_W-1:0] OutDestReg;
    logic                  OutWritesReg;
    logic                  ResultValid;
    logic [REG_ADDR_W-1:0] ResultDestReg;
    logic                  ResultWritesReg;

    modport master (
        output InValid, ALUOpIn, SrcRegA, SrcRegB, DestRegIn, WritesReg, RegDataA, RegDataB,
               Immediate, UseImm, Flush, AluResult,
        input  InReady, FirstInput, SecondInput, ALUOp, OutValid, OutDestReg, OutWritesReg,
               ResultValid, ResultDestReg, ResultWritesReg
    );

    modport slave (
        input  InValid, ALUOpIn, SrcRegA, SrcRegB, DestRegIn, WritesReg, RegDataA, RegDataB,
               Immediate, UseImm, Flush, AluResult,
        output InReady, FirstInput, SecondInput, ALUOp, OutValid, OutDestReg, OutWritesReg,
               ResultValid, ResultDestReg, ResultWritesReg
    );
endinterface

// File: rtl/alu_operand_stage_fwd_select.sv
// alu_fwd_select: per-source dependency check against the issue (S) and result (R) tags
// use_i: source is read; idx_i: source index; s_tag_i/r_tag_i: stage tags;
// reg_data_i: register-file read; alu_result_i: registered ALU output;
// hazard_o: source waits on S; data_o: forwarded or register-file operand.
module alu_fwd_select
    import alu_operand_stage_pkg::*;
(
    input  logic                  use_i,
    input  logic [REG_ADDR_W-1:0] idx_i,
    input  tag_t                  s_tag_i,
    input  tag_t                  r_tag_i,
    input  logic [DATA_WIDTH-1:0] reg_data_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  hazard_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    assign hazard_o = use_i && tag_hit(s_tag_i, idx_i);
    // an S match stalls the instruction, so only R needs a forwarding path
    assign data_o   = (use_i && tag_hit(r_tag_i, idx_i)) ? alu_result_i : reg_data_i;
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand register stage feeding the 16-bit clocked ALU
// CLK/Reset: clock and synchronous active-high reset.
// stage_if (slave): decoded instruction in (InValid/InReady handshake), register reads,
// AluResult in; FirstInput/SecondInput/ALUOp/OutValid/OutDestReg/OutWritesReg to the ALU;
// ResultValid/ResultDestReg/ResultWritesReg tag AluResult for writeback.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                CLK,
    input  logic                Reset,
    alu_operand_stage_if.slave  stage_if
);
    tag_t                  s_tag_q, s_tag_d, r_tag_q, r_tag_d;
    logic [DATA_WIDTH-1:0] first_q, first_d, second_q, second_d;
    alu_op_e               op_q, op_d;
    logic                  haz_a, haz_b, accept;
    logic [DATA_WIDTH-1:0] data_a, data_b;

    alu_fwd_select u_fwd_a (
        .use_i        (1'b1),
        .idx_i        (stage_if.SrcRegA),
        .s_tag_i      (s_tag_q),
        .r_tag_i      (r_tag_q),
        .reg_data_i   (stage_if.RegDataA),
        .alu_result_i (stage_if.AluResult),
        .hazard_o     (haz_a),
        .data_o       (data_a)
    );

    alu_fwd_select u_fwd_b (
        .use_i        (!stage_if.UseImm),
        .idx_i        (stage_if.SrcRegB),
        .s_tag_i      (s_tag_q),
        .r_tag_i      (r_tag_q),
        .reg_data_i   (stage_if.RegDataB),
        .alu_result_i (stage_if.AluResult),
        .hazard_o     (haz_b),
        .data_o       (data_b)
    );

    assign stage_if.InReady = !Reset && !(haz_a || haz_b);
    assign accept           = stage_if.InValid && stage_if.InReady;

    // anything not accepted (stall, idle or flush) issues a zeroed NOP bubble
    always_comb begin
        s_tag_d  = '0;
        first_d  = '0;
        second_d = '0;
        op_d     = ALU_NOP;
        r_tag_d  = stage_if.Flush ? '0 : s_tag_q;
        if (!stage_if.Flush && accept) begin
            s_tag_d  = '{valid: 1'b1, writes: stage_if.WritesReg, dest: stage_if.DestRegIn};
            first_d  = data_a;
            second_d = stage_if.UseImm ? sext_imm(stage_if.Immediate) : data_b;
            op_d     = alu_op_e'(stage_if.ALUOpIn);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s_tag_q  <= '0;
            r_tag_q  <= '0;
            first_q  <= '0;
            second_q <= '0;
            op_q     <= ALU_NOP;
        end else begin
            s_tag_q  <= s_tag_d;
            r_tag_q  <= r_tag_d;
            first_q  <= first_d;
            second_q <= second_d;
            op_q     <= op_d;
        end
    end

    assign stage_if.FirstInput      = first_q;
    assign stage_if.SecondInput     = second_q;
    assign stage_if.ALUOp           = op_q;
    assign stage_if.OutValid        = s_tag_q.valid;
    assign stage_if.OutDestReg      = s_tag_q.dest;
    assign stage_if.OutWritesReg    = s_tag_q.writes;
    assign stage_if.ResultValid     = r_tag_q.valid;
    assign stage_if.ResultDestReg   = r_tag_q.dest;
    assign stage_if.ResultWritesReg = r_tag_q.writes;
endmodule
